// File: rtl/shift_left_seq.sv
// Multi-cycle logical left shifter: one bit per clock, with Carry/Overflow/Zero flags.
// Valid/ready on both sides; the state is exported on dbg_state for checkers.
module shift_left_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   SHAMT,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutputSLL,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. The producer holds valid (and data) until that edge. The
  // consumer may hold OutReady low indefinitely; outputs stay frozen meanwhile.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   count;
  logic             carry_q;
  logic             ovf_q;
  logic             accept;

  assign accept = InValid && InReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (SHAMT != '0) ? SHIFT : DONE;
      SHIFT:   if (count == SHW'(1)) state_next = DONE;
      DONE:    if (OutReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Overflow looks at the pre-shift sign pair of every step, so any sign
  // change along the way sticks even if a later step flips it back.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sreg    <= '0;
      count   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= A;
            count   <= SHAMT;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        SHIFT: begin
          carry_q <= sreg[WIDTH-1];
          ovf_q   <= ovf_q | (sreg[WIDTH-1] ^ sreg[WIDTH-2]);
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          count   <= count - SHW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    InReady   = (state == IDLE) && !Reset;
    OutValid  = (state == DONE);
    OutputSLL = sreg;
    Carry     = carry_q;
    Overflow  = ovf_q;
    Zero      = OutValid && (sreg == '0);
    dbg_state = state;
  end

endmodule

// File: doc/shift_left_seq.md
Name: shift_left_seq

Overview:
- Iterative (multi-cycle) logical left shifter for the 16-bit CPU datapath. Complements the combinational arithmetic right shifter.
- Shifts one bit position per clock and produces the SLL result plus Carry, Overflow and Zero flags.
- Sits beside the ALU. The control unit drives it through a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 16, data width in bits.
- SHW, 4, shift-amount width; the maximum shift is 2^SHW-1.

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- InValid  input  1  A and SHAMT are valid.
- InReady  output  1  block can accept an operation.
- A  input  WIDTH  operand to shift.
- SHAMT  input  SHW  shift amount.
- OutValid  output  1  result and flags are valid.
- OutReady  input  1  consumer accepts the result.
- OutputSLL  output  WIDTH  A << SHAMT, zero-filled, truncated to WIDTH.
- Carry  output  1  last bit shifted out of the MSB; 0 when SHAMT=0.
- Overflow  output  1  signed overflow: the sign bit changed on any single-bit step.
- Zero  output  1  OutputSLL == 0.

Behaviour:
- Clock and reset: one clock, Clock. Reset is asynchronous and active-high. On Reset:
  - state=IDLE, shift register=0, count=0.
  - OutputSLL=0, Carry=0, Overflow=0, Zero=0, OutValid=0.
  - InReady=1 once Reset deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - InReady=1, OutValid=0.
  - Accept when InValid && InReady at a rising edge: load shift reg=A, count=SHAMT, Carry=0, Overflow=0.
  - Next state is SHIFT if SHAMT!=0, otherwise DONE.
- SHIFT:
  - InReady=0. Each edge:
    - Carry <= reg[WIDTH-1].
    - Overflow <= Overflow | (reg[WIDTH-1]^reg[WIDTH-2]).
    - reg <= {reg[WIDTH-2:0],1'b0}.
    - count <= count-1.
  - When count==1 at the edge, next state is DONE.
  - InValid is ignored while busy; A and SHAMT need not be held after acceptance.
- DONE:
  - OutValid=1. OutputSLL=reg, Zero=(reg==0); Carry and Overflow are registered values.
  - All outputs stay stable while OutReady=0 (unbounded backpressure).
  - On an edge with OutReady=1, next state is IDLE. No new accept on that same edge; InReady rises the next cycle.
- Latency:
  - Accept in cycle c gives OutValid high in cycle c+1+SHAMT.
  - Minimum throughput is one operation per SHAMT+2 cycles.
- Zero and sign:
  - Zero is combinational from the result register, gated meaningful only while OutValid=1.
  - Overflow is computed on the pre-shift value of each step, so it equals (signed A * 2^SHAMT) not representable in WIDTH bits.
- Outside DONE: OutputSLL and flags may show intermediate values; consumers use them only when OutValid=1.
- Reset mid-operation (SHIFT or DONE): return to IDLE immediately. The in-flight result is discarded and OutValid drops asynchronously.
- SHAMT=15 (maximum): exactly 15 shift steps. No wrap of count; count never underflows.

Test Plan:
- Reset mid-shift: reset, A=0x1234, SHAMT=0, then assert Reset during SHIFT of a SHAMT=15 operation -> 1 cycle after accept OutputSLL=0x1234, Carry=0, Overflow=0, Zero=0; after the mid-shift Reset, OutValid=0 immediately, all outputs 0, InReady=1 after deassert.
- Maximum shift: A=0x0001, SHAMT=15 -> OutValid in cycle c+16; OutputSLL=0x8000, Carry=0, Overflow=1, Zero=0.
- Carry out, sign preserved: A=0xC000, SHAMT=1 -> OutputSLL=0x8000, Carry=1, Overflow=0, Zero=0.
- Shift to zero: A=0x8000, SHAMT=1 -> OutputSLL=0x0000, Carry=1, Overflow=1, Zero=1.
- Multi-step flags: A=0x8001, SHAMT=4 -> OutputSLL=0x0010, Carry=0 (original bit 12), Overflow=1.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> outputs stable and InValid pulses ignored; on OutReady=1, IDLE next cycle with InReady=1; back-to-back operations accepted with correct results.
